// File: rtl/addsub_digit_serial_if.sv
// Operand/result bundle for addsub_digit_serial: request side (start, sub, cin, X, Y)
// and registered result side (Sum, Carry, Ovf, Zero, busy, done).
interface addsub_digit_serial_if #(
  parameter int N = 8
);
  logic         start;
  logic         sub;
  logic         cin;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic [N-1:0] Sum;
  logic         Carry;
  logic         Ovf;
  logic         Zero;
  logic         busy;
  logic         done;

  modport master (
    output start, sub, cin, X, Y,
    input  Sum, Carry, Ovf, Zero, busy, done
  );

  modport slave (
    input  start, sub, cin, X, Y,
    output Sum, Carry, Ovf, Zero, busy, done
  );
endinterface

// File: rtl/addsub_digit_serial.sv
// Digit-serial adder/subtractor: N-bit operands processed D bits per cycle over S = N/D steps.
// Optional macro ADDSUB_FLAGS_EN enables the Ovf/Zero flags; otherwise they are tied to 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit step per cycle, S cycles, busy = 1
// DONE  | one-cycle done pulse; start here chains the next operation
module addsub_digit_serial #(
  parameter int N = 8,
  parameter int D = 2
) (
  input logic              clk,
  input logic              rst,
  addsub_digit_serial_if.slave bus
);
  localparam int S  = N / D;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   work_q, work_d;
  logic [N-1:0]   sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_run_q, carry_run_d;
  logic           carry_q, carry_d;

  logic [D-1:0]   a_dig, b_dig, s_dig;
  logic           c_out;
  logic [N-1:0]   work_nxt;
  logic           accept;

  // Operands shift right one digit per step; result digits shift in from the top.
  always_comb begin
    a_dig = a_q[D-1:0];
    b_dig = b_q[D-1:0];
    {c_out, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry_run_q};
    work_nxt = (work_q >> D) | (N'(s_dig) << (N - D));
  end

`ifdef ADDSUB_FLAGS_EN
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
  logic c_msb_in;

  assign c_msb_in = a_dig[D-1] ^ b_dig[D-1] ^ s_dig[D-1];
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_run_d = carry_run_q;
    carry_d     = carry_q;
    accept      = 1'b0;
`ifdef ADDSUB_FLAGS_EN
    ovf_d       = ovf_q;
    zero_d      = zero_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d         = a_q >> D;
        b_d         = b_q >> D;
        work_d      = work_nxt;
        carry_run_d = c_out;
        cnt_d       = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          sum_d   = work_nxt;
          carry_d = c_out;
`ifdef ADDSUB_FLAGS_EN
          ovf_d   = c_msb_in ^ c_out;
          zero_d  = (work_nxt == '0);
`endif
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Subtraction folds into addition: invert Y and flip the carry-in.
    if (accept) begin
      a_d         = bus.X;
      b_d         = bus.Y ^ {N{bus.sub}};
      carry_run_d = bus.cin ^ bus.sub;
      work_d      = '0;
      cnt_d       = CW'(S - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_run_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_q      <= work_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_run_q <= carry_run_d;
      carry_q     <= carry_d;
    end
  end

`ifdef ADDSUB_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.Ovf  = ovf_q;
  assign bus.Zero = zero_q;
`else
  assign bus.Ovf  = 1'b0;
  assign bus.Zero = 1'b0;
`endif

  assign bus.Sum   = sum_q;
  assign bus.Carry = carry_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Directed bench for addsub_digit_serial: N=8/D=2 vector table plus corner sequences,
// and an N=8/D=8 instance for the single-step case.
module tb_addsub_digit_serial;
  localparam int N = 8;
`ifdef ADDSUB_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       sub;
    logic       cin;
    logic [7:0] sum;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_digit_serial_if #(.N(N)) bus ();
  addsub_digit_serial_if #(.N(N)) bus8 ();

  addsub_digit_serial #(.N(N), .D(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  addsub_digit_serial #(.N(N), .D(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_res(input string tag, input vec_t v);
    chk({tag, " Sum"},   32'(bus.Sum),   32'(v.sum));
    chk({tag, " Carry"}, 32'(bus.Carry), 32'(v.c));
    chk({tag, " Ovf"},   32'(bus.Ovf),   32'(v.v & FLAGS));
    chk({tag, " Zero"},  32'(bus.Zero),  32'(v.z & FLAGS));
  endtask

  // Issue one operation from IDLE and follow it to its done pulse.
  task automatic do_op(input string tag, input vec_t v);
    int n;
    int nbusy;
    @(negedge clk);
    bus.X = v.x; bus.Y = v.y; bus.sub = v.sub; bus.cin = v.cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    nbusy = bus.busy ? 1 : 0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
      if (bus.busy) nbusy++;
    end
    chk({tag, " latency"}, 32'(n), 32'd4);
    chk({tag, " busy cycles"}, 32'(nbusy), 32'd4);
    chk_res(tag, v);
    @(posedge clk); #1;
    chk({tag, " done width"}, 32'(bus.done), 32'd0);
  endtask

  vec_t vecs[10];
  vec_t b2b[4];

  initial begin
    int n;
    int ndone;
    int last_done;
    vec_t v;

    vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h0F, 8'hF0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{8'h3C, 8'h4B, 1'b0, 1'b0, 8'h87, 1'b0, 1'b1, 1'b0};

    b2b[0] = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    b2b[1] = '{8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0};
    b2b[2] = '{8'h20, 8'h30, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    b2b[3] = '{8'hC8, 8'h38, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.X = '0; bus.Y = '0;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.X = '0; bus8.Y = '0;

    // Reset, with start asserted to show reset wins.
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset Sum",   32'(bus.Sum),   32'd0);
    chk("reset Carry", 32'(bus.Carry), 32'd0);
    chk("reset Ovf",   32'(bus.Ovf),   32'd0);
    chk("reset Zero",  32'(bus.Zero),  32'd0);
    chk("reset busy",  32'(bus.busy),  32'd0);
    chk("reset done",  32'(bus.done),  32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // Start during busy is ignored; Sum holds the previous result while running.
    @(negedge clk);
    bus.X = 8'h03; bus.Y = 8'h05; bus.sub = 1'b1; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("hold Sum during run", 32'(bus.Sum), 32'h87);
    chk("ign busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.X = 8'hAA; bus.Y = 8'h11; bus.sub = 1'b0; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 2;
    while (n < 20 && !bus.done) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign latency", 32'(n), 32'd4);
    chk_res("ign", vecs[3]);
    @(posedge clk); #1;
    chk("ign no restart", 32'(bus.busy), 32'd0);

    // Start held high: back-to-back operations, done every 5 cycles.
    @(negedge clk);
    bus.X = b2b[0].x; bus.Y = b2b[0].y; bus.sub = b2b[0].sub; bus.cin = b2b[0].cin;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.X = b2b[1].x; bus.Y = b2b[1].y; bus.sub = b2b[1].sub; bus.cin = b2b[1].cin;
    last_done = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (n < 20) begin
        @(posedge clk); #1;
        n++;
        if (bus.done) break;
      end
      chk($sformatf("b2b%0d latency", k), 32'(n), 32'd4);
      if (k > 0) chk($sformatf("b2b%0d period", k), 32'(cyc - last_done), 32'd5);
      last_done = cyc;
      chk_res($sformatf("b2b%0d", k), b2b[k]);
      if (k == 3) begin
        bus.start = 1'b0;
      end else begin
        @(posedge clk); #1;
        chk($sformatf("b2b%0d no idle gap", k), 32'(bus.busy), 32'd1);
        if (k + 2 < 4) begin
          bus.X = b2b[k+2].x; bus.Y = b2b[k+2].y;
          bus.sub = b2b[k+2].sub; bus.cin = b2b[k+2].cin;
        end
      end
    end
    @(posedge clk); #1;
    chk("b2b idle after", 32'(bus.busy), 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    v = '{8'hFF, 8'h03, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
    do_op("pre_rst", v);
    @(negedge clk);
    bus.X = 8'h7F; bus.Y = 8'h01; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort Sum",   32'(bus.Sum),   32'd0);
    chk("abort Carry", 32'(bus.Carry), 32'd0);
    chk("abort busy",  32'(bus.busy),  32'd0);
    chk("abort done",  32'(bus.done),  32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    do_op("post_rst", vecs[4]);

    // D = N: single-step run, done two cycles after start.
    @(negedge clk);
    bus8.X = 8'h7F; bus8.Y = 8'h01; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    chk("d8 busy", 32'(bus8.busy), 32'd1);
    chk("d8 early done", 32'(bus8.done), 32'd0);
    @(posedge clk); #1;
    chk("d8 done", 32'(bus8.done), 32'd1);
    chk("d8 Sum", 32'(bus8.Sum), 32'h80);
    chk("d8 Carry", 32'(bus8.Carry), 32'd0);
    chk("d8 Ovf", 32'(bus8.Ovf), 32'(FLAGS));
    @(negedge clk);
    bus8.X = 8'h05; bus8.Y = 8'h07; bus8.sub = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    chk("d8 sub done", 32'(bus8.done), 32'd1);
    chk("d8 sub Sum", 32'(bus8.Sum), 32'hFE);
    chk("d8 sub Carry", 32'(bus8.Carry), 32'd0);
    @(posedge clk); #1;
    chk("d8 idle", 32'(bus8.busy | bus8.done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/addsub_digit_serial.md
ADDSUB_DIGIT_SERIAL -- requirements
Module: addsub_digit_serial

Interface
REQ-001 Parameter N, default 8: operand/result width in bits; N >= 2.
REQ-002 Parameter D, default 2: digit width processed per cycle; 1 <= D <= N, N mod D = 0; S = N/D digit steps.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled only when busy = 0.
REQ-006 sub  input  1  0 = add, 1 = subtract; captured with start.
REQ-007 cin  input  1  carry-in; captured with start.
REQ-008 X  input  N  operand A, unsigned/two's complement; captured with start.
REQ-009 Y  input  N  operand B; captured with start.
REQ-010 Sum  output  N  result, registered.
REQ-011 Carry  output  1  carry-out of MSB, registered.
REQ-012 Ovf  output  1  signed overflow flag, registered.
REQ-013 Zero  output  1  Sum == 0 flag, registered.
REQ-014 busy  output  1  high while digits are being processed.
REQ-015 done  output  1  one-cycle pulse: results valid.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE after the S-th digit step; DONE -> RUN if start, else -> IDLE.
REQ-017 Start accepted in IDLE and DONE only; start while busy = 1 ignored, captured operands unchanged.
REQ-018 On accepted start: latch X, Y ^ {N{sub}}, effective carry c0 = cin ^ sub, clear digit counter.
REQ-019 RUN: each cycle adds digit k (bits k*D+D-1..k*D) of latched operands plus running carry; writes Sum digit k; stores carry; k increments 0..S-1.
REQ-020 busy = 1 exactly in RUN (S cycles); done = 1 exactly in DONE (1 cycle); start at edge t -> done high in cycle t+S+1.
REQ-021 sub = 0, cin = 0: Sum = (X+Y) mod 2^N; sub = 1, cin = 0: Sum = (X-Y) mod 2^N; Carry = 1 means no borrow.
REQ-022 Carry = carry out of bit N-1 of final step; Ovf = carry into bit N-1 XOR carry out of bit N-1; Zero = (final Sum == 0).
REQ-023 Sum, Carry, Ovf, Zero update only at end of final step and hold until the final step of next operation; intermediate Sum digits not observable as valid before done.
REQ-024 Back-to-back: start asserted during DONE begins next operation with no idle cycle.
REQ-025 D = N: single-cycle RUN, behaves as registered adder, latency 2.

Reset
REQ-026 rst = 1 at an edge forces IDLE, busy = 0, done = 0, Sum = 0, Carry = 0, Ovf = 0, Zero = 0, counter = 0; overrides start.
REQ-027 rst mid-RUN aborts operation; no done pulse for it; next start after rst deasserts runs normally.

Configuration
REQ-028 Macro ADDSUB_FLAGS_EN defined: Ovf and Zero computed per REQ-022.
REQ-029 Macro ADDSUB_FLAGS_EN undefined: Ovf and Zero tied to 0, flag logic absent; all other behaviour identical.

Verification (N = 8, D = 2, S = 4, ADDSUB_FLAGS_EN defined unless stated)
REQ-030 X=8'h7F, Y=8'h01, sub=0, cin=0, start -> busy 4 cycles, done at t+5, Sum=8'h80, Carry=0, Ovf=1, Zero=0.
REQ-031 X=8'hFF, Y=8'h01, sub=0 -> Sum=8'h00, Carry=1, Ovf=0, Zero=1; X=8'h05, Y=8'h05, sub=1 -> Sum=8'h00, Carry=1, Zero=1.
REQ-032 X=8'h03, Y=8'h05, sub=1 -> Sum=8'hFE, Carry=0, Ovf=0; second start pulsed during busy with other operands -> ignored, result unchanged.
REQ-033 start held high continuously with new operands each DONE -> done every 5 cycles, each result matches its captured operands.
REQ-034 rst asserted in 2nd RUN cycle -> next cycle all outputs 0, IDLE, no done; subsequent 8'h10+8'h20 -> Sum=8'h30.
REQ-035 Build without ADDSUB_FLAGS_EN, repeat REQ-030 -> Sum=8'h80, Carry=0, Ovf=0, Zero=0; also N=8, D=8 -> done at t+2.
